fft_idx_cnt: RTL
================

# fft_idx_cnt

Parametrised index and stage counter for the FFT datapath. It generalises the 3-bit load/enable counter to W bits, adds a programmable limit with wrap or hold modes, and cascades a pass (stage) counter with an end-of-transform pulse. It also provides the bit-reversed index for input/output reordering. It drives butterfly address generation and twiddle selection for an N = 2^W point transform.

## Interface
Parameters:
- W, 3, index width; N = 2^W points
- STAGES, 3, passes per transform (normally W)
- SW, max(1, clog2(STAGES)), stage counter width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  load index from data and clear stage
- data  in  W  load value
- en  in  1  count enable
- lmt  in  W  terminal index, inclusive
- wrap  in  1  1 = wrap to 0 after lmt and advance stage; 0 = hold at lmt
- out  out  W  current index
- out_rev  out  W  bit-reversed out (out_rev[i] = out[W-1-i]), combinational
- stage  out  SW  current pass, 0..STAGES-1
- tc  out  1  registered flag, high while out == lmt
- last  out  1  combinational: tc & (stage == STAGES-1)
- done  out  1  one-cycle pulse at end of final pass

## Operation
- Update priority per edge: rst > load > en > hold.
- rst: out=0, stage=0, tc=0, done=0.
- load: out<=data, stage<=0, done<=0.
- en with out != lmt: out<=out+1 modulo 2^W; stage unchanged.
  - A loaded value above lmt counts up through 2^W-1, wraps to 0, then reaches lmt.
- en with out == lmt and wrap=1: out<=0.
  - If stage < STAGES-1: stage<=stage+1.
  - If stage == STAGES-1: stage<=0 and done<=1 for one cycle.
- en with out == lmt and wrap=0: out, stage hold; done stays 0. This mode is used for single-shot loads.
- en=0: all state holds; done<=0.
- tc register: after the first edge out of reset, tc<=(out_next == lmt). tc therefore tracks out in the same cycle, with no one-cycle lag.
- lmt and wrap are sampled every cycle. Changing lmt mid-pass takes effect on the next compare. If out is already above the new lmt, counting continues by modulo wrap.
- lmt=0 with wrap=1 and en=1: out stays 0 and stage advances every cycle.

## Timing
- Latency from load or en to the new out: 1 cycle. tc is valid in the same cycle as out.
- done is asserted in the cycle where out has returned to 0 and stage to 0 after the final pass.
- Full transform with load data=0, wrap=1, en held high: done appears (lmt+1)*STAGES edges after the load edge.
- rst mid-pass: the next cycle shows out=0, stage=0, tc=0, done=0. A done pending on the same edge is suppressed.
- load and en on the same edge: load wins and no increment occurs.
- out_rev and last change combinationally with out, stage, and tc.

## Test plan
- Reset: hold rst 2 cycles with en=1, lmt=0 -> out=0, stage=0, tc=0, done=0. tc=1 on the first edge after rst deasserts.
- Full transform, W=3, STAGES=3, lmt=7, wrap=1, load data=0, then en=1 for 24 cycles:
  - out runs 0..7 three times.
  - stage reads 0 → 1 → 2 → 0.
  - tc is high at out=7.
  - done is a single pulse after cycle 24.
  - out_rev sequence for the first pass is 0,4,2,6,1,5,3,7.
- Hold mode: lmt=5, wrap=0, en=1 for 10 cycles -> out stops at 5, tc stays 1, stage=0, done never asserts.
- Priority: load=1 with data=3 and en=1 at out=6 -> out=3 (not 7), stage=0. With load=1 and rst=1 together -> out=0.
- Load above limit: lmt=2, load data=6, en=1 -> out sequence 6,7,0,1,2,0. Stage increments only on leaving 2.
- Mid-operation reset: rst at stage=2, out=7 with en=1 -> no done pulse, out=0, stage=0 next cycle.

Source files
------------

// File: rtl/fft_idx_cnt_if.sv
// fft_idx_cnt_if: control and status bundle for the FFT
// index/stage counter.
interface fft_idx_cnt_if #(
  parameter int W      = 3,
  parameter int STAGES = 3
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic          load;
  logic [W-1:0]  data;
  logic          en;
  logic [W-1:0]  lmt;
  logic          wrap;
  logic [W-1:0]  out;
  logic [W-1:0]  out_rev;
  logic [SW-1:0] stage;
  logic          tc;
  logic          last;
  logic          done;

  modport master (
    output load, data, en, lmt, wrap,
    input  out, out_rev, stage, tc, last, done
  );

  modport slave (
    input  load, data, en, lmt, wrap,
    output out, out_rev, stage, tc, last, done
  );
endinterface

// File: rtl/fft_idx_cnt.sv
// fft_idx_cnt: W-bit FFT index counter with programmable limit,
// cascaded pass counter, end-of-transform pulse and bit-reversed index.
module fft_idx_cnt #(
  parameter int W      = 3,
  parameter int STAGES = 3
) (
  input logic         clk,
  input logic         rst,
  fft_idx_cnt_if.slave bus
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [SW-1:0] SLAST = SW'(STAGES - 1);

  logic [W-1:0]  cnt;
  logic [W-1:0]  cnt_nxt;
  logic [SW-1:0] stg;
  logic [SW-1:0] stg_nxt;
  logic          tc_q;
  logic          done_q;
  logic          done_nxt;
  logic          at_lmt;
  logic          at_last;

  assign at_lmt  = (cnt == bus.lmt);
  assign at_last = (stg == SLAST);

  // Next index/pass: load beats enable; at the limit either wrap
  // into the next pass or park on the limit.
  always_comb begin
    cnt_nxt  = cnt;
    stg_nxt  = stg;
    done_nxt = 1'b0;
    if (bus.load) begin
      cnt_nxt = bus.data;
      stg_nxt = '0;
    end else if (bus.en) begin
      if (!at_lmt) begin
        cnt_nxt = cnt + W'(1);
      end else if (bus.wrap) begin
        cnt_nxt = '0;
        if (at_last) begin
          stg_nxt  = '0;
          done_nxt = 1'b1;
        end else begin
          stg_nxt = stg + SW'(1);
        end
      end
    end
  end

  // State registers; tc compares the next index so it lines up with out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stg    <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      stg    <= stg_nxt;
      tc_q   <= (cnt_nxt == bus.lmt);
      done_q <= done_nxt;
    end
  end

  // Bit-reversed index for input/output reordering.
  for (genvar i = 0; i < W; i++) begin : g_rev
    assign bus.out_rev[i] = cnt[W-1-i];
  end

  assign bus.out   = cnt;
  assign bus.stage = stg;
  assign bus.tc    = tc_q;
  assign bus.last  = tc_q & at_last;
  assign bus.done  = done_q;
endmodule
